// File: rtl/psum_write_ctrl_pkg.sv
// Shared definitions for the partial-sum write controller: stall codes
// returned to the main convolution controller and the FSM state encoding.
package psum_write_ctrl_pkg;

   // Stall codes sampled by the main controller in WAIT_FOR_WRITE
   localparam logic [1:0] STALL_BUSY = 2'b00;
   localparam logic [1:0] STALL_CONT = 2'b10;
   localparam logic [1:0] STALL_STOP = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WRITE    = 2'b01,
      ST_REPORT   = 2'b10,
      ST_FINISHED = 2'b11
   } state_t;

endpackage

// File: rtl/psum_write_ctrl_sat_adder.sv
// Signed saturating adder: the sum is formed one bit wider than the operands
// and clamped to the representable range, with a flag when clamping happens.
module psum_write_ctrl_sat_adder #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] sum,
   output logic              sat
);

   logic [DATA_W:0] sum_ext_s;

   // Extended-precision add, then clamp when the two top bits disagree
   always_comb begin
      sum_ext_s = {op_a[DATA_W-1], op_a} + {op_b[DATA_W-1], op_b};
      if (sum_ext_s[DATA_W] != sum_ext_s[DATA_W-1]) begin
         sat = 1'b1;
         if (sum_ext_s[DATA_W]) begin
            sum = {1'b1, {(DATA_W-1){1'b0}}};
         end else begin
            sum = {1'b0, {(DATA_W-1){1'b1}}};
         end
      end else begin
         sat = 1'b0;
         sum = sum_ext_s[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/psum_write_ctrl.sv
// Write-buffer controller: takes the main controller's one-cycle write
// request, optionally folds in the stored partial sum with saturation, pushes
// the word into the output FIFO and reports a 2-bit stall code back.
module psum_write_ctrl
   import psum_write_ctrl_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              global_rst,
   input  logic              chip_en,
   input  logic              write_req,
   input  logic [DATA_W-1:0] result_in,
   input  logic              psum_mode,
   input  logic [DATA_W-1:0] psum_in,
   input  logic [CNT_W-1:0]  total_outputs,
   input  logic              fifo_full,
   output logic              fifo_wen,
   output logic [DATA_W-1:0] fifo_wdata,
   output logic [1:0]        stall,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy,
   output logic              sat_flag,
   output logic              protocol_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_r, state_nxt_s;
   logic [DATA_W-1:0] word_r, word_nxt_s;
   logic [1:0]        stall_r, stall_nxt_s;
   logic              fifo_wen_r, fifo_wen_nxt_s;
   logic [DATA_W-1:0] fifo_wdata_r, fifo_wdata_nxt_s;
   logic [CNT_W-1:0]  out_count_r, out_count_nxt_s;
   logic              sat_flag_r, sat_flag_nxt_s;
   logic              protocol_err_r, protocol_err_nxt_s;

   logic [DATA_W-1:0] sum_s;
   logic              sat_s;
   logic [DATA_W-1:0] add_word_s;
   logic              add_sat_s;
   logic              final_s;
   logic              cnt_room_s;

   psum_write_ctrl_sat_adder #(.DATA_W(DATA_W)) u_sat_adder (
      .op_a (result_in),
      .op_b (psum_in),
      .sum  (sum_s),
      .sat  (sat_s)
   );

   // psum_in only matters in psum mode, including for the saturation flag
   assign add_word_s = psum_mode ? sum_s : result_in;
   assign add_sat_s  = psum_mode & sat_s;

   // A zero total means an unbounded layer: never stop, counter wraps
   assign final_s    = (total_outputs != CNT_ZERO) && (out_count_r == total_outputs);
   assign cnt_room_s = (total_outputs == CNT_ZERO) || (out_count_r != total_outputs);

   // State register; global_rst is a synchronous clear above everything else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else if (global_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; a deasserted chip_en freezes the FSM
   always_comb begin
      state_nxt_s = state_r;
      if (chip_en) begin
         case (state_r)
            ST_IDLE:     state_nxt_s = write_req ? ST_WRITE : ST_IDLE;
            ST_WRITE:    state_nxt_s = fifo_full ? ST_WRITE : ST_REPORT;
            ST_REPORT:   state_nxt_s = final_s ? ST_FINISHED : ST_IDLE;
            ST_FINISHED: state_nxt_s = ST_FINISHED;
            default:     state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Next values of the registered outputs and the latched word
   always_comb begin
      stall_nxt_s        = stall_r;
      fifo_wen_nxt_s     = 1'b0;
      fifo_wdata_nxt_s   = fifo_wdata_r;
      out_count_nxt_s    = out_count_r;
      sat_flag_nxt_s     = sat_flag_r;
      protocol_err_nxt_s = protocol_err_r;
      word_nxt_s         = word_r;
      if (chip_en) begin
         case (state_r)
            ST_IDLE: begin
               stall_nxt_s = STALL_BUSY;
               if (write_req) begin
                  word_nxt_s     = add_word_s;
                  sat_flag_nxt_s = sat_flag_r | add_sat_s;
               end else begin
                  word_nxt_s     = word_r;
               end
            end
            ST_WRITE: begin
               stall_nxt_s        = STALL_BUSY;
               protocol_err_nxt_s = protocol_err_r | write_req;
               if (!fifo_full) begin
                  fifo_wen_nxt_s   = 1'b1;
                  fifo_wdata_nxt_s = word_r;
                  if (cnt_room_s) begin
                     out_count_nxt_s = out_count_r + CNT_ONE;
                  end else begin
                     out_count_nxt_s = out_count_r;
                  end
               end else begin
                  fifo_wen_nxt_s   = 1'b0;
               end
            end
            ST_REPORT: begin
               stall_nxt_s        = final_s ? STALL_STOP : STALL_CONT;
               protocol_err_nxt_s = protocol_err_r | write_req;
            end
            ST_FINISHED: begin
               stall_nxt_s = STALL_STOP;
            end
            default: begin
               stall_nxt_s = STALL_BUSY;
            end
         endcase
      end else begin
         fifo_wen_nxt_s = 1'b0;
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_r         <= {DATA_W{1'b0}};
         stall_r        <= STALL_BUSY;
         fifo_wen_r     <= 1'b0;
         fifo_wdata_r   <= {DATA_W{1'b0}};
         out_count_r    <= CNT_ZERO;
         sat_flag_r     <= 1'b0;
         protocol_err_r <= 1'b0;
      end else if (global_rst) begin
         word_r         <= {DATA_W{1'b0}};
         stall_r        <= STALL_BUSY;
         fifo_wen_r     <= 1'b0;
         fifo_wdata_r   <= {DATA_W{1'b0}};
         out_count_r    <= CNT_ZERO;
         sat_flag_r     <= 1'b0;
         protocol_err_r <= 1'b0;
      end else begin
         word_r         <= word_nxt_s;
         stall_r        <= stall_nxt_s;
         fifo_wen_r     <= fifo_wen_nxt_s;
         fifo_wdata_r   <= fifo_wdata_nxt_s;
         out_count_r    <= out_count_nxt_s;
         sat_flag_r     <= sat_flag_nxt_s;
         protocol_err_r <= protocol_err_nxt_s;
      end
   end

   assign fifo_wen     = fifo_wen_r;
   assign fifo_wdata   = fifo_wdata_r;
   assign stall        = stall_r;
   assign out_count    = out_count_r;
   assign sat_flag     = sat_flag_r;
   assign protocol_err = protocol_err_r;
   assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_psum_write_ctrl.sv
// Directed bench for psum_write_ctrl (DATA_W=16, CNT_W=3).
module tb_psum_write_ctrl;

   logic        clk;
   logic        reset;
   logic        global_rst;
   logic        chip_en;
   logic        write_req;
   logic [15:0] result_in;
   logic        psum_mode;
   logic [15:0] psum_in;
   logic [2:0]  total_outputs;
   logic        fifo_full;
   logic        fifo_wen;
   logic [15:0] fifo_wdata;
   logic [1:0]  stall;
   logic [2:0]  out_count;
   logic        busy;
   logic        sat_flag;
   logic        protocol_err;

   int n_tests;
   int n_fail;

   psum_write_ctrl #(.DATA_W(16), .CNT_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .global_rst    (global_rst),
      .chip_en       (chip_en),
      .write_req     (write_req),
      .result_in     (result_in),
      .psum_mode     (psum_mode),
      .psum_in       (psum_in),
      .total_outputs (total_outputs),
      .fifo_full     (fifo_full),
      .fifo_wen      (fifo_wen),
      .fifo_wdata    (fifo_wdata),
      .stall         (stall),
      .out_count     (out_count),
      .busy          (busy),
      .sat_flag      (sat_flag),
      .protocol_err  (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete write transaction with its latency checked cycle by cycle
   task automatic wr(input logic [15:0] res, input logic [15:0] ps, input logic mode,
                     input logic [15:0] exp_d, input logic [1:0] exp_st);
      write_req = 1'b1; result_in = res; psum_in = ps; psum_mode = mode;
      cyc();
      write_req = 1'b0;
      chk("wr_busy", 32'(busy), 32'd1);
      chk("wr_wen_early", 32'(fifo_wen), 32'd0);
      cyc();
      chk("wr_wen", 32'(fifo_wen), 32'd1);
      chk("wr_data", 32'(fifo_wdata), 32'(exp_d));
      cyc();
      chk("wr_stall", 32'(stall), 32'(exp_st));
      chk("wr_wen_off", 32'(fifo_wen), 32'd0);
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b1; global_rst = 1'b0; chip_en = 1'b1; write_req = 1'b0;
      result_in = 16'd0; psum_mode = 1'b0; psum_in = 16'd0;
      total_outputs = 3'd3; fifo_full = 1'b0;
      cyc(); cyc();
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wen", 32'(fifo_wen), 32'd0);
      chk("rst_cnt", 32'(out_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_perr", 32'(protocol_err), 32'd0);
      reset = 1'b0;
      cyc();

      // Bounded layer of three words
      wr(16'd5, 16'd0, 1'b0, 16'd5, 2'b10);
      wr(16'd7, 16'd0, 1'b0, 16'd7, 2'b10);
      wr(16'd9, 16'd0, 1'b0, 16'd9, 2'b11);
      chk("fin_cnt", 32'(out_count), 32'd3);
      write_req = 1'b1; result_in = 16'd1;
      cyc();
      write_req = 1'b0;
      chk("fin_wen", 32'(fifo_wen), 32'd0);
      cyc();
      chk("fin_wen2", 32'(fifo_wen), 32'd0);
      chk("fin_stall", 32'(stall), 32'd3);
      chk("fin_perr", 32'(protocol_err), 32'd0);
      chk("fin_cnt2", 32'(out_count), 32'd3);

      // global_rst in FINISHED, colliding with a write request
      global_rst = 1'b1; write_req = 1'b1;
      cyc();
      global_rst = 1'b0; write_req = 1'b0;
      chk("grst_stall", 32'(stall), 32'd0);
      chk("grst_cnt", 32'(out_count), 32'd0);
      chk("grst_busy", 32'(busy), 32'd0);
      cyc();
      chk("grst_busy2", 32'(busy), 32'd0);

      // Partial-sum arithmetic, unbounded layer
      total_outputs = 3'd0;
      wr(16'd100, -16'sd300, 1'b1, 16'hFF38, 2'b10);
      chk("nosat_flag", 32'(sat_flag), 32'd0);
      wr(16'd1234, 16'd30000, 1'b0, 16'd1234, 2'b10);
      chk("mode0_flag", 32'(sat_flag), 32'd0);
      wr(16'd30000, 16'd10000, 1'b1, 16'h7FFF, 2'b10);
      chk("satp_flag", 32'(sat_flag), 32'd1);
      wr(-16'sd30000, -16'sd10000, 1'b1, 16'h8000, 2'b10);
      chk("satn_flag", 32'(sat_flag), 32'd1);
      chk("psum_cnt", 32'(out_count), 32'd4);

      // FIFO back-pressure for four cycles
      global_rst = 1'b1; cyc(); global_rst = 1'b0;
      fifo_full = 1'b1; write_req = 1'b1; result_in = 16'd42; psum_mode = 1'b0;
      cyc();
      write_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("full_wen", 32'(fifo_wen), 32'd0);
         chk("full_stall", 32'(stall), 32'd0);
      end
      fifo_full = 1'b0;
      cyc();
      chk("full_wen_go", 32'(fifo_wen), 32'd1);
      chk("full_data", 32'(fifo_wdata), 32'd42);
      fifo_full = 1'b1;
      cyc();
      chk("full_stall_go", 32'(stall), 32'd2);
      fifo_full = 1'b0;
      cyc();
      chk("full_cnt", 32'(out_count), 32'd1);

      // Second request while WRITE
      write_req = 1'b1; result_in = 16'd11;
      cyc();
      result_in = 16'd99;
      cyc();
      write_req = 1'b0;
      chk("perr_wen", 32'(fifo_wen), 32'd1);
      chk("perr_data", 32'(fifo_wdata), 32'd11);
      chk("perr_flag", 32'(protocol_err), 32'd1);
      cyc();
      chk("perr_stall", 32'(stall), 32'd2);
      cyc();
      chk("perr_wen2", 32'(fifo_wen), 32'd0);
      cyc();
      chk("perr_wen3", 32'(fifo_wen), 32'd0);
      chk("perr_cnt", 32'(out_count), 32'd2);

      // Counter wrap with an unbounded layer
      global_rst = 1'b1; cyc(); global_rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wr(16'(i + 20), 16'd0, 1'b0, 16'(i + 20), 2'b10);
      end
      chk("wrap_cnt", 32'(out_count), 32'd1);

      // chip_en freeze
      write_req = 1'b1; chip_en = 1'b0; result_in = 16'd77;
      cyc();
      chk("ce_ignore", 32'(busy), 32'd0);
      chip_en = 1'b1;
      cyc();
      write_req = 1'b0; chip_en = 1'b0;
      cyc();
      chk("ce_wen", 32'(fifo_wen), 32'd0);
      chk("ce_busy", 32'(busy), 32'd1);
      cyc();
      chk("ce_wen2", 32'(fifo_wen), 32'd0);
      chip_en = 1'b1;
      cyc();
      chk("ce_wen_go", 32'(fifo_wen), 32'd1);
      chk("ce_data", 32'(fifo_wdata), 32'd77);
      cyc();
      chk("ce_stall", 32'(stall), 32'd2);
      chk("ce_cnt", 32'(out_count), 32'd2);

      // Async reset while stuck in WRITE
      fifo_full = 1'b1; write_req = 1'b1; result_in = 16'd55;
      cyc();
      write_req = 1'b0;
      cyc();
      #2 reset = 1'b1;
      #1;
      chk("arst_wen", 32'(fifo_wen), 32'd0);
      chk("arst_cnt", 32'(out_count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_data", 32'(fifo_wdata), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      cyc();
      reset = 1'b0; fifo_full = 1'b0;
      cyc();
      chk("arst_wen2", 32'(fifo_wen), 32'd0);
      cyc();
      chk("arst_wen3", 32'(fifo_wen), 32'd0);
      chk("arst_busy2", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
